tree_scatter: RTL
=================

TREE_SCATTER -- requirements
Module: tree_scatter

Interface
REQ-001 Parameter WIDTH, 16, number of leaf outputs; SHALL equal CHUNK**L for an integer L >= 1.
REQ-002 Parameter CHUNK, 4, fan-out per tree level; SHALL be a power of two >= 2.
REQ-003 Parameter DATA_W, 8, payload width in bits.
REQ-004 Derived constant LEVELS = log_CHUNK(WIDTH); derived constant AW = log2(WIDTH); neither SHALL be overridable.
REQ-005 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, asynchronous and active-high.
REQ-007 in_valid  input  1  root offers a transaction.
REQ-008 in_ready  output  1  root accepts the transaction this cycle.
REQ-009 in_addr  input  AW  target leaf index, read as LEVELS base-CHUNK digits, most significant digit first.
REQ-010 in_bcast  input  1  when 1, deliver to all WIDTH leaves and ignore in_addr.
REQ-011 in_data  input  DATA_W  payload.
REQ-012 out_valid  output  WIDTH  per-leaf delivery pending.
REQ-013 out_ready  input  WIDTH  per-leaf acceptance.
REQ-014 out_data  output  DATA_W  payload of the output-stage transaction, shared by all leaves.
REQ-015 deliv_cnt  output  16  count of fully delivered transactions; wraps modulo 2**16.

Function
REQ-016 The block SHALL contain LEVELS pipeline stages, each holding valid, data and a WIDTH-bit leaf mask.
REQ-017 A root handshake SHALL occur when in_valid && in_ready.
REQ-018 On a root handshake, stage 1 SHALL load a mask covering the WIDTH/CHUNK leaves selected by digit 0, or all leaves if in_bcast=1.
REQ-019 Moving from stage k to stage k+1, the mask SHALL narrow to the WIDTH/CHUNK**(k+1) leaves selected by digit k; broadcast masks SHALL stay all-ones.
REQ-020 After stage LEVELS, a unicast mask SHALL be exactly one-hot at bit in_addr.
REQ-021 out_valid SHALL equal the stage-LEVELS mask ANDed with the stage-LEVELS valid bit; out_data SHALL equal the stage-LEVELS data.
REQ-022 Each leaf i with out_valid[i] && out_ready[i] SHALL have its mask bit cleared at the next edge; other pending bits SHALL hold.
REQ-023 The output stage SHALL empty at the edge where all remaining mask bits are accepted; deliv_cnt SHALL increment by 1 at that edge.
REQ-024 Stage k (k < LEVELS) SHALL advance when stage k+1 is empty or emptying in the same cycle.
REQ-025 in_ready SHALL equal (stage 1 empty) OR (stage 1 advancing) and SHALL NOT depend combinationally on in_valid.
REQ-026 The block SHALL sustain one transaction per cycle when out_ready is all-ones.
REQ-027 Latency SHALL be exactly LEVELS cycles from root handshake to out_valid when no stall occurs (LEVELS = 2 at defaults).
REQ-028 out_data and out_valid SHALL stay stable while any bit remains pending.
REQ-029 Transactions SHALL be delivered in acceptance order; no stage SHALL be overwritten while it is valid and not advancing.
REQ-030 out_ready bits for leaves with out_valid = 0 SHALL be ignored.

Reset
REQ-031 While rst=1, all stage valid bits SHALL be 0, out_valid = 0, in_ready = 0, out_data = 0 and deliv_cnt = 0.
REQ-032 When rst asserts mid-operation, in-flight transactions SHALL be discarded without delivery.
REQ-033 in_ready SHALL rise in the first cycle after rst deasserts.

Verification
REQ-034 Unicast: in_addr=9, in_data=0xA5, out_ready all-ones -> at handshake+2 cycles out_valid=0x0200, out_data=0xA5 for 1 cycle; deliv_cnt=1.
REQ-035 Broadcast with partial stall: in_bcast=1, data=0x3C; out_ready=0x00FF then 0xFF00 -> out_valid=0xFFFF, then 0xFF00, then 0; deliv_cnt increments once.
REQ-036 Back-to-back: addresses 0,5,10,15 on consecutive cycles with out_ready all-ones -> out_valid sequence 0x0001, 0x0020, 0x0400, 0x8000 on consecutive cycles; in_ready stays 1.
REQ-037 Backpressure: out_ready=0 with in_valid held -> accepts exactly LEVELS transactions, then in_ready=0; releasing out_ready drains them in order.
REQ-038 Reset mid-flight: assert rst with 2 transactions in flight -> out_valid=0 and deliv_cnt=0 immediately, no delivery afterwards.
REQ-039 Counter wrap: 65536 deliveries -> deliv_cnt returns to 0x0000.

Source files
------------

// File: rtl/tree_scatter.sv
// Multi-level scatter tree: a root transaction is narrowed one base-CHUNK digit
// per stage and delivered to one leaf (unicast) or all leaves (broadcast).
module tree_scatter #(
    parameter int WIDTH  = 16,
    parameter int CHUNK  = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [$clog2(WIDTH)-1:0] in_addr,
    input  logic              in_bcast,
    input  logic [DATA_W-1:0] in_data,
    output logic [WIDTH-1:0]  out_valid,
    input  logic [WIDTH-1:0]  out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       deliv_cnt
);
    localparam int AW     = $clog2(WIDTH);
    localparam int CB     = $clog2(CHUNK);
    localparam int LEVELS = AW / CB;
    localparam int OS     = LEVELS - 1;

    logic [LEVELS-1:0] v;
    logic [LEVELS-1:0] b;
    logic [DATA_W-1:0] d [LEVELS];
    logic [AW-1:0]     a [LEVELS];
    logic [WIDTH-1:0]  m [LEVELS];

    logic [LEVELS-1:0] load;
    logic [LEVELS-1:0] leave;
    logic [LEVELS-1:0] ld_b;
    logic [DATA_W-1:0] ld_d [LEVELS];
    logic [AW-1:0]     ld_a [LEVELS];
    logic [WIDTH-1:0]  ld_m [LEVELS];
    logic              done;
    logic              free0;
    logic [WIDTH-1:0]  acc;

    // Leaves whose top (lvl+1) digits match those of addr.
    function automatic logic [WIDTH-1:0] sel(input int lvl,
                                             input logic [AW-1:0] addr);
        logic [WIDTH-1:0] r;
        logic [AW-1:0]    idx;
        int               sh;
        r  = '0;
        sh = AW - (lvl + 1) * CB;
        for (int i = 0; i < WIDTH; i++) begin
            idx  = AW'(i);
            r[i] = ((idx >> sh) == (addr >> sh));
        end
        return r;
    endfunction

    assign out_valid = m[OS] & {WIDTH{v[OS]}};
    assign out_data  = d[OS];
    assign acc       = out_valid & out_ready;
    assign in_ready  = !rst && free0;

    always_comb begin
        logic f;
        done  = v[OS] && ((m[OS] & ~out_ready) == '0);
        leave = '0;
        leave[OS] = done;
        f = !v[OS] || done;
        for (int j = OS - 1; j >= 0; j--) begin
            leave[j] = v[j] && f;
            f = !v[j] || (v[j] && f);
        end
        free0 = f;
        load    = '0;
        load[0] = in_valid && in_ready;
        ld_b[0] = in_bcast;
        ld_d[0] = in_data;
        ld_a[0] = in_addr;
        ld_m[0] = in_bcast ? '1 : sel(0, in_addr);
        for (int j = 1; j < LEVELS; j++) begin
            load[j] = leave[j-1];
            ld_b[j] = b[j-1];
            ld_d[j] = d[j-1];
            ld_a[j] = a[j-1];
            ld_m[j] = b[j-1] ? '1 : (m[j-1] & sel(j, a[j-1]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v         <= '0;
            b         <= '0;
            deliv_cnt <= '0;
            for (int j = 0; j < LEVELS; j++) begin
                d[j] <= '0;
                a[j] <= '0;
                m[j] <= '0;
            end
        end else begin
            deliv_cnt <= deliv_cnt + {15'd0, done};
            for (int j = 0; j < LEVELS; j++) begin
                if (load[j]) begin
                    v[j] <= 1'b1;
                    b[j] <= ld_b[j];
                    d[j] <= ld_d[j];
                    a[j] <= ld_a[j];
                    m[j] <= ld_m[j];
                end else if (j == OS) begin
                    // Output stage retires leaf by leaf until fully accepted.
                    if (done) v[j] <= 1'b0;
                    else      m[j] <= m[j] & ~acc;
                end else if (leave[j]) begin
                    v[j] <= 1'b0;
                end
            end
        end
    end
endmodule
